// File: rtl/control_unit_team1.sv
// rtl/control_unit_team1.sv - basic-computer style control sequencer (fetch/decode/execute timing)
module control_unit_team1 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] ir,
    input  logic        dr_is_zero,
    output logic [2:0]  bus_sel,
    output logic        ar_ld,
    output logic        ar_inc,
    output logic        pc_ld,
    output logic        pc_inc,
    output logic        dr_ld,
    output logic        dr_inc,
    output logic        ac_ld,
    output logic        ir_ld,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [1:0]  alu_op,
    output logic [2:0]  sc,
    output logic        busy,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Bus source encodings driven onto bus_sel.
    localparam logic [2:0] BUS_AR  = 3'b001;
    localparam logic [2:0] BUS_PC  = 3'b010;
    localparam logic [2:0] BUS_DR  = 3'b011;
    localparam logic [2:0] BUS_AC  = 3'b100;
    localparam logic [2:0] BUS_IR  = 3'b101;
    localparam logic [2:0] BUS_MEM = 3'b111;

    // Memory-reference opcodes (ir[14:12]); 111 is the register/halt group.
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_LDA = 3'b010;
    localparam logic [2:0] OP_STA = 3'b011;
    localparam logic [2:0] OP_BUN = 3'b100;
    localparam logic [2:0] OP_BSA = 3'b101;
    localparam logic [2:0] OP_ISZ = 3'b110;
    localparam logic [2:0] OP_REG = 3'b111;

    // Full set of control outputs for one cycle. isz_t6 marks the ISZ write-back
    // cycle so pc_inc can follow dr_is_zero, which only settles during that cycle.
    typedef struct packed {
        logic [2:0] bus_sel;
        logic       ar_ld;
        logic       ar_inc;
        logic       pc_ld;
        logic       pc_inc;
        logic       dr_ld;
        logic       dr_inc;
        logic       ac_ld;
        logic       ir_ld;
        logic       mem_rd;
        logic       mem_wr;
        logic [1:0] alu_op;
        logic       isz_t6;
    } ctrl_t;

    state_t     state_q, state_d;
    logic [2:0] sc_q, sc_d;
    logic       i_q, i_d;
    logic [2:0] op_q, op_d;
    ctrl_t      ctrl_q, ctrl_d;

    // Address field and register-reference bits other than HLT are datapath concerns.
    logic ir_unused;
    assign ir_unused = ^ir[11:1];

    // Strobe pattern for a given state / timing step / latched instruction fields.
    function automatic ctrl_t decode(input state_t st, input logic [2:0] t,
                                     input logic ind, input logic [2:0] opc);
        ctrl_t c;
        c = '0;
        if (st == ST_RUN) begin
            case (t)
                3'd0: begin
                    c.bus_sel = BUS_PC;
                    c.ar_ld   = 1'b1;
                end
                3'd1: begin
                    c.bus_sel = BUS_MEM;
                    c.mem_rd  = 1'b1;
                    c.ir_ld   = 1'b1;
                    c.pc_inc  = 1'b1;
                end
                3'd2: begin
                    c.bus_sel = BUS_IR;
                    c.ar_ld   = 1'b1;
                end
                3'd3: begin
                    // Indirect address fetch; direct and register-group do nothing.
                    if (opc != OP_REG && ind) begin
                        c.bus_sel = BUS_MEM;
                        c.mem_rd  = 1'b1;
                        c.ar_ld   = 1'b1;
                    end
                end
                3'd4: begin
                    case (opc)
                        OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                            c.bus_sel = BUS_MEM;
                            c.mem_rd  = 1'b1;
                            c.dr_ld   = 1'b1;
                        end
                        OP_STA: begin
                            c.bus_sel = BUS_AC;
                            c.mem_wr  = 1'b1;
                        end
                        OP_BUN: begin
                            c.bus_sel = BUS_AR;
                            c.pc_ld   = 1'b1;
                        end
                        OP_BSA: begin
                            c.bus_sel = BUS_PC;
                            c.mem_wr  = 1'b1;
                            c.ar_inc  = 1'b1;
                        end
                        default: c = '0;
                    endcase
                end
                3'd5: begin
                    case (opc)
                        OP_AND, OP_ADD, OP_LDA: begin
                            c.ac_ld  = 1'b1;
                            c.alu_op = opc[1:0];
                        end
                        OP_BSA: begin
                            c.bus_sel = BUS_AR;
                            c.pc_ld   = 1'b1;
                        end
                        OP_ISZ: c.dr_inc = 1'b1;
                        default: c = '0;
                    endcase
                end
                3'd6: begin
                    if (opc == OP_ISZ) begin
                        c.bus_sel = BUS_DR;
                        c.mem_wr  = 1'b1;
                        c.isz_t6  = 1'b1;
                    end
                end
                default: c = '0;
            endcase
        end
        return c;
    endfunction

    // Next state, sequence count and instruction-field latch.
    always_comb begin
        state_d = state_q;
        sc_d    = sc_q;
        i_d     = i_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                sc_d = 3'd0;
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sc_d = sc_q + 3'd1;
                case (sc_q)
                    3'd2: begin
                        i_d  = ir[15];
                        op_d = ir[14:12];
                    end
                    3'd3: begin
                        if (op_q == OP_REG) begin
                            sc_d = 3'd0;
                            if (!i_q && ir[0]) begin
                                state_d = ST_HALT;
                            end
                        end
                    end
                    3'd4: begin
                        if (op_q inside {OP_STA, OP_BUN, OP_REG}) begin
                            sc_d = 3'd0;
                        end
                    end
                    3'd5: begin
                        if (op_q != OP_ISZ) begin
                            sc_d = 3'd0;
                        end
                    end
                    3'd6:    sc_d = 3'd0;
                    default: if (sc_q == 3'd7) sc_d = 3'd0;
                endcase
            end
            default: begin
                state_d = ST_IDLE;
                sc_d    = 3'd0;
            end
        endcase
    end

    // Outputs are decoded one cycle early so they come straight from flops.
    always_comb begin
        ctrl_d = decode(state_d, sc_d, i_d, op_d);
    end

    // Single state register for the sequencer, latched fields and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sc_q    <= 3'd0;
            i_q     <= 1'b0;
            op_q    <= 3'd0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            i_q     <= i_d;
            op_q    <= op_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus_sel = ctrl_q.bus_sel;
    assign ar_ld   = ctrl_q.ar_ld;
    assign ar_inc  = ctrl_q.ar_inc;
    assign pc_ld   = ctrl_q.pc_ld;
    assign pc_inc  = ctrl_q.pc_inc | (ctrl_q.isz_t6 & dr_is_zero);
    assign dr_ld   = ctrl_q.dr_ld;
    assign dr_inc  = ctrl_q.dr_inc;
    assign ac_ld   = ctrl_q.ac_ld;
    assign ir_ld   = ctrl_q.ir_ld;
    assign mem_rd  = ctrl_q.mem_rd;
    assign mem_wr  = ctrl_q.mem_wr;
    assign alu_op  = ctrl_q.alu_op;
    assign sc      = sc_q;
    assign busy    = (state_q == ST_RUN);
    assign halted  = (state_q == ST_HALT);

endmodule

// File: tb/tb_control_unit_team1.sv
// tb/tb_control_unit_team1.sv - table-driven bench for control_unit_team1
module tb_control_unit_team1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] ir;
    logic        dr_is_zero;
    logic [2:0]  bus_sel;
    logic        ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc, ac_ld, ir_ld, mem_rd, mem_wr;
    logic [1:0]  alu_op;
    logic [2:0]  sc;
    logic        busy, halted;

    control_unit_team1 dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ir(ir), .dr_is_zero(dr_is_zero),
        .bus_sel(bus_sel), .ar_ld(ar_ld), .ar_inc(ar_inc), .pc_ld(pc_ld), .pc_inc(pc_inc),
        .dr_ld(dr_ld), .dr_inc(dr_inc), .ac_ld(ac_ld), .ir_ld(ir_ld), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .alu_op(alu_op), .sc(sc), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    // Strobe vector order: {ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc, ac_ld, ir_ld, mem_rd, mem_wr}
    localparam logic [9:0] S_ARLD  = 10'b1000000000;
    localparam logic [9:0] S_ARINC = 10'b0100000000;
    localparam logic [9:0] S_PCLD  = 10'b0010000000;
    localparam logic [9:0] S_PCINC = 10'b0001000000;
    localparam logic [9:0] S_DRLD  = 10'b0000100000;
    localparam logic [9:0] S_DRINC = 10'b0000010000;
    localparam logic [9:0] S_ACLD  = 10'b0000001000;
    localparam logic [9:0] S_IRLD  = 10'b0000000100;
    localparam logic [9:0] S_MRD   = 10'b0000000010;
    localparam logic [9:0] S_MWR   = 10'b0000000001;

    typedef struct {
        logic        start;
        logic [15:0] ir;
        logic        dz;
        logic [2:0]  bus;
        logic [9:0]  stb;
        logic [1:0]  alu;
        logic [2:0]  sc;
        logic        busy;
        logic        halted;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [19:0] outs();
        return {bus_sel, ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc, ac_ld, ir_ld,
                mem_rd, mem_wr, alu_op, sc, busy, halted};
    endfunction

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got bus=%b stb=%b alu=%b sc=%0d busy=%b halt=%b, want bus=%b stb=%b alu=%b sc=%0d busy=%b halt=%b",
                     name, act[19:17], act[16:7], act[6:5], act[4:2], act[1], act[0],
                     exp[19:17], exp[16:7], exp[6:5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    task automatic add(input logic st, input logic [15:0] i, input logic dz, input logic [2:0] b,
                       input logic [9:0] s, input logic [1:0] a, input logic [2:0] t,
                       input logic bz, input logic h);
        vec_t v;
        v.start = st; v.ir = i; v.dz = dz; v.bus = b; v.stb = s; v.alu = a;
        v.sc = t; v.busy = bz; v.halted = h;
        vecs.push_back(v);
    endtask

    // One RUN cycle, start low, dr_is_zero low.
    task automatic rr(input logic [15:0] i, input logic [2:0] t, input logic [2:0] b,
                      input logic [9:0] s, input logic [1:0] a);
        add(1'b0, i, 1'b0, b, s, a, t, 1'b1, 1'b0);
    endtask

    task automatic fetch(input logic [15:0] i);
        rr(i, 3'd0, 3'b010, S_ARLD, 2'b00);
        rr(i, 3'd1, 3'b111, S_MRD | S_IRLD | S_PCINC, 2'b00);
        rr(i, 3'd2, 3'b101, S_ARLD, 2'b00);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; ir = 16'h0000; dr_is_zero = 1'b0;

        // Reset / idle
        add(1'b0, 16'h2105, 1'b0, 3'b000, 10'd0, 2'b00, 3'd0, 1'b0, 1'b0);
        add(1'b0, 16'h2105, 1'b0, 3'b000, 10'd0, 2'b00, 3'd0, 1'b0, 1'b0);
        add(1'b1, 16'h2105, 1'b0, 3'b000, 10'd0, 2'b00, 3'd0, 1'b0, 1'b0);
        // LDA direct
        fetch(16'h2105);
        rr(16'h2105, 3'd3, 3'b000, 10'd0, 2'b00);
        rr(16'h2105, 3'd4, 3'b111, S_MRD | S_DRLD, 2'b00);
        rr(16'h2105, 3'd5, 3'b000, S_ACLD, 2'b10);
        // STA indirect
        fetch(16'hB0A0);
        rr(16'hB0A0, 3'd3, 3'b111, S_MRD | S_ARLD, 2'b00);
        rr(16'hB0A0, 3'd4, 3'b100, S_MWR, 2'b00);
        // ISZ, DR reaches zero
        fetch(16'h6010);
        rr(16'h6010, 3'd3, 3'b000, 10'd0, 2'b00);
        rr(16'h6010, 3'd4, 3'b111, S_MRD | S_DRLD, 2'b00);
        rr(16'h6010, 3'd5, 3'b000, S_DRINC, 2'b00);
        add(1'b0, 16'h6010, 1'b1, 3'b011, S_MWR | S_PCINC, 2'b00, 3'd6, 1'b1, 1'b0);
        // ISZ, DR non-zero
        fetch(16'h6010);
        rr(16'h6010, 3'd3, 3'b000, 10'd0, 2'b00);
        rr(16'h6010, 3'd4, 3'b111, S_MRD | S_DRLD, 2'b00);
        rr(16'h6010, 3'd5, 3'b000, S_DRINC, 2'b00);
        add(1'b0, 16'h6010, 1'b0, 3'b011, S_MWR, 2'b00, 3'd6, 1'b1, 1'b0);
        // BSA with start held high during RUN
        add(1'b1, 16'h5020, 1'b0, 3'b010, S_ARLD, 2'b00, 3'd0, 1'b1, 1'b0);
        add(1'b1, 16'h5020, 1'b0, 3'b111, S_MRD | S_IRLD | S_PCINC, 2'b00, 3'd1, 1'b1, 1'b0);
        rr(16'h5020, 3'd2, 3'b101, S_ARLD, 2'b00);
        rr(16'h5020, 3'd3, 3'b000, 10'd0, 2'b00);
        rr(16'h5020, 3'd4, 3'b010, S_MWR | S_ARINC, 2'b00);
        rr(16'h5020, 3'd5, 3'b001, S_PCLD, 2'b00);
        // HLT, then restart
        fetch(16'h7001);
        rr(16'h7001, 3'd3, 3'b000, 10'd0, 2'b00);
        add(1'b0, 16'h7001, 1'b0, 3'b000, 10'd0, 2'b00, 3'd0, 1'b0, 1'b1);
        add(1'b0, 16'h7001, 1'b0, 3'b000, 10'd0, 2'b00, 3'd0, 1'b0, 1'b1);
        add(1'b1, 16'h7001, 1'b0, 3'b000, 10'd0, 2'b00, 3'd0, 1'b0, 1'b1);
        // NOP (register group without HLT bit)
        fetch(16'h7000);
        rr(16'h7000, 3'd3, 3'b000, 10'd0, 2'b00);
        // AND direct
        fetch(16'h0005);
        rr(16'h0005, 3'd3, 3'b000, 10'd0, 2'b00);
        rr(16'h0005, 3'd4, 3'b111, S_MRD | S_DRLD, 2'b00);
        rr(16'h0005, 3'd5, 3'b000, S_ACLD, 2'b00);
        // BUN indirect
        fetch(16'hC010);
        rr(16'hC010, 3'd3, 3'b111, S_MRD | S_ARLD, 2'b00);
        rr(16'hC010, 3'd4, 3'b001, S_PCLD, 2'b00);
        rr(16'h0000, 3'd0, 3'b010, S_ARLD, 2'b00);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < vecs.size(); k++) begin
            start = vecs[k].start;
            ir = vecs[k].ir;
            dr_is_zero = vecs[k].dz;
            #1;
            check($sformatf("row%0d", k), outs(),
                  {vecs[k].bus, vecs[k].stb, vecs[k].alu, vecs[k].sc, vecs[k].busy, vecs[k].halted});
            @(negedge clk);
        end

        // ADD aborted by asynchronous reset at T4
        start = 1'b0; dr_is_zero = 1'b0; ir = 16'h1005; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("add_t4", outs(), {3'b111, S_MRD | S_DRLD, 2'b00, 3'd4, 1'b1, 1'b0});
        #2 rst_n = 1'b0;
        #1;
        check("add_async_rst", outs(), 20'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("post_rst%0d", k), outs(), 20'd0);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_unit_team1.md
CONTROL_UNIT_TEAM1 -- requirements
Module: control_unit_team1

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port start  input  1  run request; sampled only in IDLE or HALT.
REQ-004 SHALL have port ir  input  16  current IR contents: ir[15]=I, ir[14:12]=opcode, ir[0]=HLT bit.
REQ-005 SHALL have port dr_is_zero  input  1  DR==0 flag, valid in cycle following dr_inc.
REQ-006 SHALL have port bus_sel  output  3  bus source: 000 none, 001 AR, 010 PC, 011 DR, 100 AC, 101 IR, 110 TR, 111 MEM.
REQ-007 SHALL have ports ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, dr_inc, ac_ld, ir_ld, mem_rd, mem_wr  output  1 each  register/memory strobes, one-cycle pulses.
REQ-008 SHALL have port alu_op  output  2  AC source when ac_ld: 00 AC&DR, 01 AC+DR, 10 DR.
REQ-009 SHALL have ports sc  output  3  sequence count T0..T6; busy  output  1  state==RUN; halted  output  1  state==HALT.

Function
REQ-010 SHALL implement states IDLE, RUN, HALT; IDLE->RUN and HALT->RUN when start=1, sc=0 on entry.
REQ-011 SHALL ignore start while in RUN.
REQ-012 SHALL drive all strobes 0, bus_sel=000, alu_op=00 outside RUN.
REQ-013 SHALL, in RUN, increment sc each cycle and clear sc to 0 on the final cycle of each instruction.
REQ-014 SHALL at T0 assert bus_sel=010, ar_ld (AR<-PC).
REQ-015 SHALL at T1 assert bus_sel=111, mem_rd, ir_ld, pc_inc (IR<-M[AR], PC<-PC+1).
REQ-016 SHALL at T2 assert bus_sel=101, ar_ld (AR<-IR[11:0]) and register I=ir[15], op=ir[14:12] internally.
REQ-017 SHALL at T3, if op!=111 and I=1, assert bus_sel=111, mem_rd, ar_ld (indirect); if I=0 assert nothing.
REQ-018 SHALL at T3, if op=111, I=0, ir[0]=1, clear sc and enter HALT (HLT); any other op=111 code SHALL clear sc, no strobes (NOP).
REQ-019 AND/ADD/LDA (op 000/001/010) SHALL: T4 bus_sel=111, mem_rd, dr_ld; T5 ac_ld with alu_op 00/01/10, sc<-0.
REQ-020 STA (011) SHALL at T4 assert bus_sel=100, mem_wr, sc<-0.
REQ-021 BUN (100) SHALL at T4 assert bus_sel=001, pc_ld, sc<-0.
REQ-022 BSA (101) SHALL: T4 bus_sel=010, mem_wr, ar_inc; T5 bus_sel=001, pc_ld, sc<-0.
REQ-023 ISZ (110) SHALL: T4 bus_sel=111, mem_rd, dr_ld; T5 dr_inc; T6 bus_sel=011, mem_wr, pc_inc iff dr_is_zero, sc<-0.
REQ-024 SHALL assert at most one bus source per cycle and never mem_rd with mem_wr.
REQ-025 Instruction lengths SHALL be: HLT/NOP 4, STA/BUN 5, AND/ADD/LDA/BSA 6, ISZ 7 cycles, independent of I.
REQ-026 sc SHALL never exceed 6; any illegal sc value SHALL force sc<-0 with no strobes.

Reset
REQ-027 SHALL on rst_n=0 immediately (asynchronously) set state=IDLE, sc=0, latched I/op=0, all outputs 0.
REQ-028 SHALL abort any instruction in progress on reset; no strobe SHALL be issued in the cycle after rst_n rises.
REQ-029 SHALL remain in IDLE after reset until start=1.

Verification
REQ-030 Reset then start=1, ir=16'h2105 (LDA direct): T0 bus_sel=010/ar_ld, T1 111/mem_rd/ir_ld/pc_inc, T2 101/ar_ld, T3 none, T4 111/dr_ld, T5 ac_ld alu_op=10, next cycle sc=0.
REQ-031 ir=16'hB0A0 (STA indirect): T3 bus_sel=111, mem_rd, ar_ld; T4 bus_sel=100, mem_wr; instruction 5 cycles.
REQ-032 ir=16'h6010 (ISZ) with dr_is_zero=1 at T6: T6 bus_sel=011, mem_wr, pc_inc=1; repeat with dr_is_zero=0 -> pc_inc=0.
REQ-033 ir=16'h7001 (HLT): after T3 halted=1, busy=0, all strobes 0; start=1 -> busy=1, sc=0, T0 strobes next.
REQ-034 ir=16'h5020 (BSA): T4 bus_sel=010, mem_wr, ar_inc; T5 bus_sel=001, pc_ld; plus start=1 during RUN has no effect.
REQ-035 rst_n pulled low at T4 of ADD: outputs 0 same cycle without clock edge, state IDLE, sc=0, ac_ld never asserted.
